// File: rtl/wired_bus_rx.sv
// Open-drain single-wire bus receiver. The line is synchronised and then majority
// filtered, LSB-first frames are decoded, and each good frame is presented on a valid/ready port.
module wired_bus_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_W - 1);

  typedef enum logic [2:0] {WAIT_HI, IDLE, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic              s1, s2, filt;
  logic [2:0]        h;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] shreg;
  logic              tick, sample_bit, stop_ok, stop_bad, load;

  // A pulse one clock wide sets only one tap of h, so the majority vote
  // rejects it. Two or more taps pass through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      h    <= 3'b000;
      filt <= 1'b0;
    end else begin
      s1   <= line;
      s2   <= s1;
      h    <= {h[1:0], s2};
      filt <= (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
    end
  end

  assign tick = (cnt == '0);

  always_comb begin
    state_nxt  = state;
    sample_bit = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      WAIT_HI: if (filt) state_nxt = IDLE;
      IDLE:    if (!filt) state_nxt = START;
      START:   if (tick) state_nxt = filt ? IDLE : DATA;
      DATA: if (tick) begin
        sample_bit = 1'b1;
        if (idx == LAST) state_nxt = STOP;
      end
      STOP: if (tick) begin
        if (filt) begin
          stop_ok   = 1'b1;
          state_nxt = IDLE;
        end else begin
          stop_bad  = 1'b1;
          state_nxt = WAIT_HI;
        end
      end
      default: state_nxt = WAIT_HI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_HI;
    else        state <= state_nxt;
  end

  // The counter preloads the half period while the FSM is waiting, so the start sample falls mid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= HALF;
      idx   <= '0;
      shreg <= '0;
    end else begin
      if (state == IDLE || state == WAIT_HI) cnt <= HALF;
      else if (tick)                         cnt <= FULL;
      else                                   cnt <= cnt - 1'b1;
      if (state == START)   idx <= '0;
      else if (sample_bit)  idx <= idx + 1'b1;
      if (sample_bit) shreg[idx] <= filt;
    end
  end

  // A new frame loads when the port is empty or is being drained in the same clock.
  assign load = stop_ok & (~rx_valid | rx_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) rx_data <= shreg;
      if (load)          rx_valid <= 1'b1;
      else if (rx_ready) rx_valid <= 1'b0;
      frame_err <= stop_bad;
      overrun   <= stop_ok & rx_valid & ~rx_ready;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_wired_bus_rx.sv
// Directed bench for wired_bus_rx: two open-drain drivers share a pulled-up net.
// A negedge monitor tallies the output events, and the directed steps check them against hand-derived values.
module tb_wired_bus_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_ready = 1'b0;
  logic       a_drv = 1'b1;
  logic       b_drv = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  tri1 bus;
  assign bus = a_drv ? 1'bz : 1'b0;
  assign bus = b_drv ? 1'bz : 1'b0;

  wired_bus_rx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .line(bus),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int       acc_cnt = 0, vhi_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, rise_cyc = -1;
  logic [7:0] acc_data = 8'h00;
  logic     prev_v = 1'b0;
  always @(negedge clk) begin
    if (rx_valid && !prev_v) rise_cyc = cyc;
    if (rx_valid) vhi_cnt = vhi_cnt + 1;
    if (rx_valid && rx_ready) begin
      acc_cnt  = acc_cnt + 1;
      acc_data = rx_data;
    end
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    if (overrun)   ovr_cnt  = ovr_cnt + 1;
    prev_v = rx_valid;
  end

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame = start 0, 8 data bits LSB first, stop. Returns with the stop level still driven.
  task automatic send(input bit use_a, input bit use_b, input logic [7:0] da,
                      input logic [7:0] db, input bit stop_a);
    logic [9:0] fa, fb;
    fa = {stop_a, da, 1'b0};
    fb = {1'b1, db, 1'b0};
    for (int i = 0; i < 10; i++) begin
      a_drv = use_a ? fa[i] : 1'b1;
      b_drv = use_b ? fb[i] : 1'b1;
      tick(CPB);
    end
  endtask

  int n0, a0, v0, f0, o0;

  initial begin
    // Reset with the bus released
    tick(3);
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_busy", 32'(busy), 1);
    rst_n = 1'b1;
    tick(5);
    chk("arm_busy_e5", 32'(busy), 1);
    tick(1);
    chk("arm_busy_e6", 32'(busy), 0);
    tick(10);

    // 0xA5 with the consumer always ready
    rx_ready = 1'b1;
    a0 = acc_cnt; v0 = vhi_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    n0 = cyc;
    send(1, 0, 8'hA5, 8'hFF, 1);
    tick(5);
    chk("a5_data", 32'(acc_data), 32'hA5);
    chk("a5_rise_cyc", rise_cyc - n0, 158);
    chk("a5_vhi", vhi_cnt - v0, 1);
    chk("a5_acc", acc_cnt - a0, 1);
    chk("a5_ferr", ferr_cnt - f0, 0);
    chk("a5_ovr", ovr_cnt - o0, 0);

    // Back-to-back with a stalled consumer, so the second frame overruns
    rx_ready = 1'b0;
    a0 = acc_cnt; o0 = ovr_cnt;
    send(1, 0, 8'h3C, 8'hFF, 1);
    chk("b2b_first_data", 32'(rx_data), 32'h3C);
    chk("b2b_first_valid", 32'(rx_valid), 1);
    send(1, 0, 8'hC3, 8'hFF, 1);
    tick(5);
    chk("b2b_data_kept", 32'(rx_data), 32'h3C);
    chk("b2b_valid", 32'(rx_valid), 1);
    chk("b2b_ovr", ovr_cnt - o0, 1);
    chk("b2b_no_acc", acc_cnt - a0, 0);
    rx_ready = 1'b1;
    tick(1);
    chk("b2b_drain_valid", 32'(rx_valid), 0);
    chk("b2b_drain_data", 32'(acc_data), 32'h3C);

    // A 1-clock glitch, then a short low pulse that is a false start
    a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    a_drv = 1'b0; tick(1);
    a_drv = 1'b1; tick(30);
    a_drv = 1'b0; tick(6);
    a_drv = 1'b1; tick(40);
    chk("glitch_acc", acc_cnt - a0, 0);
    chk("glitch_ferr", ferr_cnt - f0, 0);
    chk("glitch_ovr", ovr_cnt - o0, 0);
    chk("glitch_busy", 32'(busy), 0);
    chk("glitch_valid", 32'(rx_valid), 0);

    // A zero stop bit followed by a held-low bus gives a framing error and a re-arm
    a0 = acc_cnt; f0 = ferr_cnt;
    send(1, 0, 8'h55, 8'hFF, 0);
    tick(40);
    chk("ferr_count", ferr_cnt - f0, 1);
    chk("ferr_valid", 32'(rx_valid), 0);
    chk("ferr_no_acc", acc_cnt - a0, 0);
    chk("ferr_busy_low", 32'(busy), 1);
    a_drv = 1'b1;
    tick(20);
    chk("ferr_rearm", 32'(busy), 0);
    send(1, 0, 8'h0F, 8'hFF, 1);
    tick(5);
    chk("after_ferr_data", 32'(acc_data), 32'h0F);
    chk("after_ferr_acc", acc_cnt - a0, 1);
    chk("after_ferr_ferr", ferr_cnt - f0, 1);

    // Reset in mid-DATA, released while the line is still held low
    a0 = acc_cnt; f0 = ferr_cnt;
    a_drv = 1'b0; tick(CPB);
    a_drv = 1'b1; tick(CPB);
    a_drv = 1'b0; tick(10);
    rst_n = 1'b0;
    tick(3);
    chk("midrst_busy", 32'(busy), 1);
    chk("midrst_valid", 32'(rx_valid), 0);
    rst_n = 1'b1;
    tick(20);
    chk("lowhold_busy", 32'(busy), 1);
    a_drv = 1'b1;
    tick(10);
    chk("lowhold_rearm", 32'(busy), 0);
    send(1, 0, 8'h81, 8'hFF, 1);
    tick(5);
    chk("post_rst_data", 32'(acc_data), 32'h81);
    chk("post_rst_acc", acc_cnt - a0, 1);
    chk("post_rst_ferr", ferr_cnt - f0, 0);

    // Driver A is released while B sends, then both drive at once (wired-AND)
    a0 = acc_cnt;
    send(0, 1, 8'hFF, 8'h7E, 1);
    tick(5);
    chk("solo_b_data", 32'(acc_data), 32'h7E);
    send(1, 1, 8'h3C, 8'hA6, 1);
    tick(5);
    chk("wand_data", 32'(acc_data), 32'h24);
    chk("wand_acc", acc_cnt - a0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wired_bus_rx.md
# wired_bus_rx

Receiver for a single-wire, open-drain shared bus: any node pulls the line low, and a weak pull-up returns it high when all nodes release. The block synchronises and glitch-filters the resolved bus net, then decodes LSB-first frames (start 0, DATA_W data bits, stop 1). Each frame is delivered on a valid/ready port, with framing-error and overrun reporting. It sits at the listening end of the bus opposite the strength-resolved drivers, one instance per node.

## Interface
- CLKS_PER_BIT, 16: clocks per bit period; even, ≥4.
- DATA_W, 8: data bits per frame, 1..16.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- line  in  1  resolved bus net. The pull-up is on the net (tri1 / pull1 resolution), so a released bus reads 1.
- rx_data  out  DATA_W  last good frame, bit 0 = first data bit received.
- rx_valid  out  1  rx_data holds an unconsumed frame.
- rx_ready  in  1  consumer accepts rx_data when high with rx_valid.
- frame_err  out  1  one-clock pulse: stop bit sampled 0.
- overrun  out  1  one-clock pulse: frame completed while a previous frame was still pending.
- busy  out  1  high in every FSM state other than IDLE.

## Operation
- Front end:
  - Two-flop synchroniser s1→s2, then a 3-tap history h[2:0] of s2.
  - filt is a register holding majority(h).
  - All of these reset to 0.
  - A low or high pulse ≤1 clock wide never reaches filt; a pulse ≥2 clocks wide does.
- FSM states: WAIT_HI, IDLE, START, DATA, STOP. Reset state is WAIT_HI.
- WAIT_HI: go to IDLE when filt=1. This ensures the receiver arms only after the bus has been seen released.
- IDLE: when filt=0, go to START and load the bit counter cnt = CLKS_PER_BIT/2−1.
- START:
  - cnt decrements each clock. At cnt=0 (mid start bit), sample filt.
  - filt=1: false start, go to IDLE.
  - filt=0: go to DATA with bit index=0 and cnt=CLKS_PER_BIT−1.
- DATA:
  - At each cnt=0, shift filt into the shift register at position [bit index], reload cnt, and increment the index.
  - After DATA_W samples, go to STOP.
- STOP: at cnt=0, sample filt.
  - filt=1, rx_valid=0 (or rx_ready=1 in that cycle): load rx_data and set rx_valid. Go to IDLE.
  - filt=1, rx_valid=1, rx_ready=0: keep old rx_data, pulse overrun, drop the new frame. Go to IDLE.
  - filt=0: pulse frame_err, discard data, leave rx_data and rx_valid unchanged. Go to WAIT_HI (a break or stuck-low bus must release before re-arming).
- Output handshake: rx_valid clears on any clock where rx_valid & rx_ready, unless a new frame loads in that same clock, in which case rx_valid stays 1.
- rx_data is stable while rx_valid=1.
- A bus held low by contention or another driver looks like start and data zeros, not an error, until the stop sample.

## Timing
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=1 (WAIT_HI). rst_n assertion mid-frame aborts immediately.
- After rst_n release with line high: filt=1 on the 5th rising edge, IDLE on the 6th, busy=0 from then on.
- A clean falling edge on line reaches filt 5 clocks later.
- Let D be the first clock in IDLE with filt=0. Then:
  - start sample at D+CLKS_PER_BIT/2;
  - data bit k sampled at D+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT;
  - stop sampled at D+CLKS_PER_BIT/2+(DATA_W+1)·CLKS_PER_BIT.
- rx_valid, frame_err and overrun change on the clock after the stop sample. With defaults that is D+153.
- Back-to-back frames are supported: the stop bit is one period and the next start may begin immediately. IDLE is reached 1 clock after the stop sample, so the next falling edge of filt is detected without loss.
- Consumer throughput: one accept per clock. No combinational path from rx_ready to any output.

## Test plan
- Reset with line high, then send 0xA5 at defaults, rx_ready=1 → rx_data=0xA5 and rx_valid high for exactly 1 clock, at D+153. frame_err=0, overrun=0.
- Send 0x3C then 0xC3 back-to-back with rx_ready=0 → rx_data=0x3C, rx_valid=1, overrun pulses once at the second frame end, rx_data still 0x3C. Raise rx_ready → rx_valid drops the next clock.
- 1-clock low glitch on idle line, then a 6-clock low pulse (< CLKS_PER_BIT/2) → no start, or a false start returning to IDLE. No outputs change.
- Frame 0x55 with stop bit driven 0 and line held low 40 clocks → frame_err pulses once, rx_valid stays 0, busy=1 until line high. A following 0x0F frame is then received correctly.
- Assert rst_n low mid-DATA of a frame, release with line low 20 clocks, then send 0x81 → no output from the aborted or low-held segment, 0x81 received.
- Two open-drain drivers on a tri1 net: one releases (z), the other sends 0x7E → 0x7E received. Both driving conflicting frames → the wired-AND of the two frames is received.
